// File: rtl/instruction_fetch_stage.sv
// IF stage plus IF/ID pipeline register for the 16-bit MIPS pipeline.
// Owns the PC and fetches one instruction per cycle over a req/ready handshake.
// A hazard stall freezes the PC and IF/ID. A taken branch from EX redirects the PC and squashes.
module instruction_fetch_stage #(
  parameter int unsigned                   PC_WIDTH    = 8,
  parameter int unsigned                   INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]           RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0]        NOP_INSTR   = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pipeline_stall_n,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_ready,
  output logic [PC_WIDTH-1:0]    if_id_pc,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic                   if_id_valid
);

  typedef enum logic [0:0] {
    StBoot,
    StFetch
  } state_e;

  // Decoded per-cycle action; priority between the inputs is resolved once, here.
  typedef enum logic [2:0] {
    ActHold,
    ActBranch,
    ActStall,
    ActWait,
    ActAdvance
  } action_e;

  state_e                   state_q, state_d;
  action_e                  action;
  logic [PC_WIDTH-1:0]      pc_q, pc_d;
  logic [PC_WIDTH-1:0]      if_id_pc_q, if_id_pc_d;
  logic [INSTR_WIDTH-1:0]   if_id_instr_q, if_id_instr_d;
  logic                     if_id_valid_q, if_id_valid_d;

  // Boot lasts exactly one cycle after reset release, then fetching runs until the next reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:  state_d = StFetch;
      StFetch: state_d = StFetch;
      default: state_d = StBoot;
    endcase
  end

  // Select what this edge does. A branch beats a stall, and a stall beats a memory wait state.
  // During boot everything holds, including any branch request.
  always_comb begin
    action = ActHold;
    if (state_q == StFetch) begin
      if (branch_taken) begin
        action = ActBranch;
      end else if (!pipeline_stall_n) begin
        action = ActStall;
      end else if (!imem_ready) begin
        action = ActWait;
      end else begin
        action = ActAdvance;
      end
    end
  end

  // Next-state of the PC and IF/ID register for the selected action.
  always_comb begin
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    unique case (action)
      ActBranch: begin
        // The instruction fetched this cycle is squashed; the target is fetched next cycle.
        pc_d          = branch_target;
        if_id_pc_d    = branch_target;
        if_id_instr_d = NOP_INSTR;
        if_id_valid_d = 1'b0;
      end
      ActStall: begin
        // Freeze. Data returned by memory this cycle is dropped and refetched later.
      end
      ActWait: begin
        if_id_instr_d = NOP_INSTR;
        if_id_valid_d = 1'b0;
      end
      ActAdvance: begin
        if_id_instr_d = imem_rdata;
        if_id_pc_d    = pc_q;
        if_id_valid_d = 1'b1;
        // Wraps from the top of the address space back to zero.
        pc_d          = pc_q + PC_WIDTH'(1);
      end
      default: begin
      end
    endcase
  end

  // State, PC and IF/ID register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      if_id_pc_q    <= RESET_PC;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  // Request depends only on the state register, so no input reaches the outputs combinationally.
  assign imem_req    = (state_q == StFetch);
  assign imem_addr   = pc_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios followed by randomized traffic,
// compared against a cycle-level reference model of the fetch rules.
module tb_instruction_fetch_stage;

  localparam int PW = 8;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pipeline_stall_n = 1'b1;
  logic          branch_taken = 1'b0;
  logic [PW-1:0] branch_target = '0;
  logic          imem_ready = 1'b1;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic [PW-1:0] if_id_pc;
  logic [IW-1:0] if_id_instr;
  logic          if_id_valid;

  logic [IW-1:0] rom [256];

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit            m_booted;
  logic [PW-1:0] m_pc;
  logic [PW-1:0] m_ipc;
  logic [IW-1:0] m_instr;
  logic          m_valid;

  instruction_fetch_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pipeline_stall_n (pipeline_stall_n),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .imem_ready       (imem_ready),
    .if_id_pc         (if_id_pc),
    .if_id_instr      (if_id_instr),
    .if_id_valid      (if_id_valid)
  );

  always #5 clk = ~clk;

  // Memory returns junk when not ready so a wrongly captured word is visible.
  assign imem_rdata = imem_ready ? rom[imem_addr] : 16'hBAD0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".req"},   32'(imem_req),    32'(m_booted));
    chk({tag, ".addr"},  32'(imem_addr),   32'(m_pc));
    chk({tag, ".pc"},    32'(if_id_pc),    32'(m_ipc));
    chk({tag, ".instr"}, 32'(if_id_instr), 32'(m_instr));
    chk({tag, ".valid"}, 32'(if_id_valid), 32'(m_valid));
  endtask

  task automatic model_reset();
    m_booted = 1'b0;
    m_pc     = '0;
    m_ipc    = '0;
    m_instr  = 16'h0000;
    m_valid  = 1'b0;
  endtask

  // One clock edge of the fetch rules, first matching rule wins.
  task automatic model_edge(input logic s, input logic b, input logic [PW-1:0] t, input logic r);
    if (!m_booted) begin
      m_booted = 1'b1;
    end else if (b) begin
      m_pc    = t;
      m_ipc   = t;
      m_instr = 16'h0000;
      m_valid = 1'b0;
    end else if (!s) begin
      // frozen
    end else if (!r) begin
      m_instr = 16'h0000;
      m_valid = 1'b0;
    end else begin
      m_instr = rom[m_pc];
      m_ipc   = m_pc;
      m_valid = 1'b1;
      m_pc    = m_pc + 8'd1;
    end
  endtask

  // Apply inputs for one cycle, advance one edge, then compare.
  task automatic tick(input logic s, input logic b, input logic [PW-1:0] t, input logic r,
                      input string tag);
    pipeline_stall_n = s;
    branch_taken     = b;
    branch_target    = t;
    imem_ready       = r;
    @(posedge clk);
    model_edge(s, b, t, r);
    #1;
    check_all(tag);
  endtask

  // Async reset in mid-cycle, immediate check, release between edges, check boot cycle.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk({tag, ".boot_req"}, 32'(imem_req), 32'(0));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = IW'($urandom);
    for (int i = 0; i < 16; i++) rom[i] = 16'h1000 + IW'(i);
    model_reset();

    // T1 reset and boot
    do_reset("t1");
    tick(1, 1, 8'h33, 1, "t1_boot_branch_ignored");
    chk("t1_req", 32'(imem_req), 32'(1));
    chk("t1_addr", 32'(imem_addr), 32'(0));
    chk("t1_valid", 32'(if_id_valid), 32'(0));

    // T2 straight line
    tick(1, 0, 0, 1, "t2_0");
    chk("t2_instr0", 32'(if_id_instr), 32'h1000);
    tick(1, 0, 0, 1, "t2_1");
    chk("t2_instr1", 32'(if_id_instr), 32'h1001);
    tick(1, 0, 0, 1, "t2_2");
    chk("t2_instr2", 32'(if_id_instr), 32'h1002);
    chk("t2_pc2", 32'(if_id_pc), 32'(2));
    tick(1, 0, 0, 1, "t2_3");
    tick(1, 0, 0, 1, "t2_4");

    // T3 stall holding pc=4 (with a wait state mixed in: no bubble)
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, (i != 1), "t3_stall");
      chk("t3_ipc", 32'(if_id_pc), 32'(4));
      chk("t3_addr", 32'(imem_addr), 32'(5));
      chk("t3_valid", 32'(if_id_valid), 32'(1));
    end
    tick(1, 0, 0, 1, "t3_release");
    chk("t3_next", 32'(if_id_pc), 32'(5));

    // T5 wait states at pc=7
    tick(1, 0, 0, 1, "t5_pre");
    for (int i = 0; i < 2; i++) begin
      tick(1, 0, 0, 0, "t5_wait");
      chk("t5_valid", 32'(if_id_valid), 32'(0));
      chk("t5_instr", 32'(if_id_instr), 32'h0000);
    end
    tick(1, 0, 0, 1, "t5_resume");
    chk("t5_pc", 32'(if_id_pc), 32'(7));

    // T4 branch overriding stall
    tick(0, 1, 8'h40, 1, "t4_branch");
    chk("t4_valid", 32'(if_id_valid), 32'(0));
    chk("t4_addr", 32'(imem_addr), 32'h40);
    tick(1, 0, 0, 1, "t4_target");
    chk("t4_ipc", 32'(if_id_pc), 32'h40);

    // Back-to-back branches: latest target wins
    tick(1, 1, 8'h20, 1, "bb_1");
    tick(1, 1, 8'h30, 1, "bb_2");
    chk("bb_addr", 32'(imem_addr), 32'h30);

    // T6 wrap then async reset mid-stall
    tick(1, 1, 8'hFF, 1, "t6_branch");
    tick(1, 0, 0, 1, "t6_wrap");
    chk("t6_addr", 32'(imem_addr), 32'h00);
    chk("t6_ipc", 32'(if_id_pc), 32'hFF);
    tick(0, 0, 0, 1, "t6_stall");
    do_reset("t6");
    chk("t6_rst_valid", 32'(if_id_valid), 32'(0));
    tick(1, 0, 0, 1, "t6_boot");

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rnd_rst");
      end else begin
        tick(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), PW'($urandom),
             ($urandom_range(0, 3) != 0), "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
